// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the conv tile sequencer: geometry, instruction word layout, FSM states.
// No logic here; the instruction struct field order matches the core's 47-bit inst bus.
package conv_seq_pkg;

  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int KSIZE    = 3;
  localparam int IN_W     = 6;
  localparam int OUT_W    = IN_W - KSIZE + 1;
  localparam int ADDR_W   = 11;
  localparam int GAP      = 4;
  localparam int LEN_KIJ  = KSIZE * KSIZE;
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int EXEC_END = LEN_NIJ + ROW + COL;

  localparam int INST_W = 47;
  localparam int CNT_W  = 6;
  localparam int K_W    = 4;
  localparam int O_W    = 4;
  localparam int OC_W   = 2;

  localparam int B_CEN_X    = 46;
  localparam int B_WEN_X    = 45;
  localparam int B_A_X      = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_P      = 20;
  localparam int B_CEN_W    = 19;
  localparam int B_WEN_W    = 18;
  localparam int B_A_W      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic              cen_x;
    logic              wen_x;
    logic [ADDR_W-1:0] a_x;
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [ADDR_W-1:0] a_p;
    logic              cen_w;
    logic              wen_w;
    logic [ADDR_W-1:0] a_w;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  // All SRAMs deselected and write-disabled, every strobe low.
  localparam logic [INST_W-1:0] IDLE_BITS =
      (47'd1 << B_CEN_X) | (47'd1 << B_WEN_X) |
      (47'd1 << B_CEN_P) | (47'd1 << B_WEN_P) |
      (47'd1 << B_CEN_W) | (47'd1 << B_WEN_W);
  localparam inst_t IDLE_WORD = inst_t'(IDLE_BITS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_LOAD,
    S_GAP,
    S_A_EXEC,
    S_O_DRAIN,
    S_ACC_CLR,
    S_ACC_RD,
    S_ACC_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// Psum SRAM address for tap k of output (orow,ocol): k*LEN_NIJ + (orow+k/KSIZE)*IN_W + ocol+k%KSIZE.
// Purely combinational; consumed the same cycle by the sequencer's registered inst word.
module acc_addr_gen
  import conv_seq_pkg::*;
(
  input  logic [OC_W-1:0]   orow,
  input  logic [OC_W-1:0]   ocol,
  input  logic [K_W-1:0]    k,
  output logic [ADDR_W-1:0] a_p
);

  logic [ADDR_W-1:0] krow;
  logic [ADDR_W-1:0] kcol;

  always_comb begin
    krow = ADDR_W'(k / K_W'(KSIZE));
    kcol = ADDR_W'(k % K_W'(KSIZE));
    a_p  = ADDR_W'(k) * ADDR_W'(LEN_NIJ)
         + (ADDR_W'(orow) + krow) * ADDR_W'(IN_W)
         + ADDR_W'(ocol) + kcol;
  end

endmodule

// File: rtl/conv_sequencer.sv
// Drives core.inst through a full 3x3 conv tile (9 kij passes, then 16 output accumulations).
// All outputs registered (1 cycle after state); psum drain only issues ofifo_rd while ofifo_valid is high.
module conv_sequencer
  import conv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              sfu_clr,
  output logic              out_valid,
  output logic [O_W-1:0]    o_idx,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  cnt_t              cnt, cnt_n;
  cnt_t              writes, writes_n;
  logic [K_W-1:0]    kij, kij_n;
  logic [O_W-1:0]    o_cnt, o_cnt_n;
  inst_t             inst_q, inst_n;
  logic              sfu_clr_n;
  logic              out_valid_n;
  logic              done_n;
  logic              drain_en;
  logic [ADDR_W-1:0] acc_a_p;

  acc_addr_gen u_acc_addr (
    .orow (o_cnt[2*OC_W-1:OC_W]),
    .ocol (o_cnt[OC_W-1:0]),
    .k    (cnt[K_W-1:0]),
    .a_p  (acc_a_p)
  );

  assign drain_en = ((state == S_A_EXEC) || (state == S_O_DRAIN)) &&
                    ofifo_valid && (writes < CNT_W'(LEN_NIJ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      writes    <= '0;
      kij       <= '0;
      o_cnt     <= '0;
      inst_q    <= IDLE_WORD;
      sfu_clr   <= 1'b0;
      out_valid <= 1'b0;
      o_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      writes    <= writes_n;
      kij       <= kij_n;
      o_cnt     <= o_cnt_n;
      inst_q    <= inst_n;
      sfu_clr   <= sfu_clr_n;
      out_valid <= out_valid_n;
      if (out_valid_n) begin
        o_idx <= o_cnt;
      end
      busy      <= (state != S_IDLE) && (state != S_DONE);
      done      <= done_n;
    end
  end

  assign inst = inst_q;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    writes_n    = writes;
    kij_n       = kij;
    o_cnt_n     = o_cnt;
    sfu_clr_n   = 1'b0;
    out_valid_n = 1'b0;
    done_n      = 1'b0;
    inst_n      = IDLE_WORD;

    // SRAM data arrives one cycle after the read, so consumers key off the previous word.
    inst_n.ififo_wr = ~inst_q.cen_w;
    inst_n.l0_wr    = ~inst_q.cen_x;
    inst_n.acc      = ~inst_q.cen_p & inst_q.wen_p;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_W_FETCH;
          cnt_n    = '0;
          writes_n = '0;
          kij_n    = '0;
          o_cnt_n  = '0;
        end
      end

      S_W_FETCH: begin
        inst_n.cen_w = 1'b0;
        inst_n.a_w   = ADDR_W'(kij) * ADDR_W'(COL) + ADDR_W'(cnt);
        if (cnt == CNT_W'(COL - 1)) begin
          state_n = S_W_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_W_LOAD: begin
        inst_n.ififo_rd = 1'b1;
        inst_n.load     = 1'b1;
        if (cnt == CNT_W'(ROW + COL - 2)) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          state_n  = S_A_EXEC;
          cnt_n    = '0;
          writes_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_A_EXEC: begin
        if (cnt < CNT_W'(LEN_NIJ)) begin
          inst_n.cen_x = 1'b0;
          inst_n.a_x   = ADDR_W'(cnt);
        end
        // Execute runs until the last activation has flushed through the array.
        if (cnt >= CNT_W'(2)) begin
          inst_n.l0_rd   = 1'b1;
          inst_n.execute = 1'b1;
        end
        if (cnt == CNT_W'(EXEC_END - 1)) begin
          state_n = S_O_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_O_DRAIN: begin
        if (writes == CNT_W'(LEN_NIJ)) begin
          cnt_n = '0;
          if (kij == K_W'(LEN_KIJ - 1)) begin
            state_n = S_ACC_CLR;
            o_cnt_n = '0;
          end else begin
            state_n = S_W_FETCH;
            kij_n   = kij + 1'b1;
          end
        end
      end

      S_ACC_CLR: begin
        sfu_clr_n = 1'b1;
        state_n   = S_ACC_RD;
        cnt_n     = '0;
      end

      S_ACC_RD: begin
        inst_n.cen_p = 1'b0;
        inst_n.wen_p = 1'b1;
        inst_n.a_p   = acc_a_p;
        if (cnt == CNT_W'(LEN_KIJ - 1)) begin
          state_n = S_ACC_OUT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // First cycle carries the last acc; second flags the finished output so the
      // next clear never lands on the same cycle as out_valid.
      S_ACC_OUT: begin
        if (cnt == CNT_W'(1)) begin
          out_valid_n = 1'b1;
          cnt_n       = '0;
          if (o_cnt == O_W'(LEN_ONIJ - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ACC_CLR;
            o_cnt_n = o_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (drain_en) begin
      inst_n.ofifo_rd = 1'b1;
      inst_n.cen_p    = 1'b0;
      inst_n.wen_p    = 1'b0;
      inst_n.a_p      = ADDR_W'(kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(writes);
      writes_n        = writes + 1'b1;
    end
  end

endmodule
